// File: rtl/xava_result_queue_if.sv
// X-IF result channel between the result queue and the CPU.
// master: queue side, drives the packet. slave: CPU side, drives ready.
interface xava_result_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned RD_W   = 5
) ();

  logic              result_valid;
  logic              result_ready;
  logic [ID_W-1:0]   result_id;
  logic [RD_W-1:0]   result_rd;
  logic [DATA_W-1:0] result_data;
  logic              result_we;

  modport master (
    output result_valid,
    output result_id,
    output result_rd,
    output result_data,
    output result_we,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result_id,
    input  result_rd,
    input  result_data,
    input  result_we,
    output result_ready
  );

endinterface

// File: rtl/xava_result_queue.sv
// In-order result tracker between the AVA accelerator and the X-IF result channel.
// Entries are allocated at issue, filled by accelerator results in age order,
// marked committed/killed by ID, and retired strictly from the head.
module xava_result_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned RD_W   = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // issue / allocation
  input  logic                   iss_valid_i,
  output logic                   iss_ready_o,
  input  logic [ID_W-1:0]        iss_id_i,
  input  logic [RD_W-1:0]        iss_rd_i,
  input  logic                   iss_wb_i,
  // commit / kill
  input  logic                   commit_valid_i,
  input  logic [ID_W-1:0]        commit_id_i,
  input  logic                   commit_kill_i,
  // accelerator results
  input  logic                   acc_rvalid_i,
  input  logic [DATA_W-1:0]      acc_result_i,
  // X-IF result channel
  xava_result_queue_if.master    res,
  // status
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] idx_t;
  typedef logic [AW:0]   ptr_t;

  typedef struct packed {
    logic              vld;
    logic              wb;
    logic              done;
    logic              cmt;
    logic              kill;
    logic [ID_W-1:0]   id;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  ptr_t   head_q, head_d;
  ptr_t   tail_q, tail_d;
  logic   err_q, err_d;

  idx_t   head_idx, tail_idx;
  idx_t   age_idx [DEPTH];
  ptr_t   count;
  entry_t head_e;
  logic   alloc, present, silent, pop;
  logic   cpl_hit, cmt_hit, dup_live, bypass;
  idx_t   cpl_idx, cmt_idx;

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];
  assign count    = tail_q - head_q;
  assign full_o   = (count == ptr_t'(DEPTH));
  assign empty_o  = (count == '0);
  assign count_o  = count;
  assign err_o    = err_q;

  // Ready depends only on registered occupancy: no pass-through when full.
  assign iss_ready_o = !full_o;
  assign alloc       = iss_valid_i && iss_ready_o;

  // Head retirement decode.
  assign head_e  = ent_q[head_idx];
  assign present = head_e.vld && head_e.wb && head_e.done && head_e.cmt && !head_e.kill;
  // A killed wb entry waits for done so its accelerator result is consumed.
  assign silent  = head_e.vld && ((head_e.done && head_e.kill) || (!head_e.wb && head_e.cmt));
  assign pop     = silent || (present && res.result_ready);

  // Packet is gated by valid so it reads zero when nothing is offered.
  assign res.result_valid = present;
  assign res.result_we    = present;
  assign res.result_id    = present ? head_e.id   : '0;
  assign res.result_rd    = present ? head_e.rd   : '0;
  assign res.result_data  = present ? head_e.data : '0;

  // Physical slot indices listed oldest first.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_idx[i] = head_idx + idx_t'(i);
    end
  end

  // Age-ordered searches for completion target, commit target and duplicate IDs.
  always_comb begin
    cpl_hit  = 1'b0;
    cpl_idx  = '0;
    cmt_hit  = 1'b0;
    cmt_idx  = '0;
    dup_live = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!cpl_hit && ent_q[age_idx[i]].vld && ent_q[age_idx[i]].wb &&
          !ent_q[age_idx[i]].done) begin
        cpl_hit = 1'b1;
        cpl_idx = age_idx[i];
      end
      if (!cmt_hit && ent_q[age_idx[i]].vld && (ent_q[age_idx[i]].id == commit_id_i)) begin
        cmt_hit = 1'b1;
        cmt_idx = age_idx[i];
      end
      if (ent_q[i].vld && (ent_q[i].id == iss_id_i)) begin
        dup_live = 1'b1;
      end
    end
  end

  // A commit with no live match lands on the entry being allocated this cycle.
  assign bypass = commit_valid_i && !cmt_hit && alloc && (iss_id_i == commit_id_i);

  // Next-state for entries, pointers and the sticky error flag.
  always_comb begin
    ent_d  = ent_q;
    head_d = head_q + ptr_t'(pop);
    tail_d = tail_q + ptr_t'(alloc);
    err_d  = err_q;

    if (pop) begin
      ent_d[head_idx].vld = 1'b0;
    end

    if (acc_rvalid_i) begin
      if (cpl_hit) begin
        ent_d[cpl_idx].data = acc_result_i;
        ent_d[cpl_idx].done = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (commit_valid_i && cmt_hit) begin
      if (commit_kill_i) begin
        ent_d[cmt_idx].kill = 1'b1;
      end else begin
        ent_d[cmt_idx].cmt = 1'b1;
      end
    end

    if (alloc) begin
      ent_d[tail_idx].vld  = 1'b1;
      ent_d[tail_idx].wb   = iss_wb_i;
      ent_d[tail_idx].done = !iss_wb_i;
      ent_d[tail_idx].cmt  = bypass && !commit_kill_i;
      ent_d[tail_idx].kill = bypass && commit_kill_i;
      ent_d[tail_idx].id   = iss_id_i;
      ent_d[tail_idx].rd   = iss_rd_i;
      ent_d[tail_idx].data = '0;
      if (dup_live) begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_xava_result_queue.sv
// Directed bench for xava_result_queue with a scoreboard-driven result monitor.
module tb_xava_result_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned RD_W   = 5;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } pkt_t;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   iss_valid_i;
  logic                   iss_ready_o;
  logic [ID_W-1:0]        iss_id_i;
  logic [RD_W-1:0]        iss_rd_i;
  logic                   iss_wb_i;
  logic                   commit_valid_i;
  logic [ID_W-1:0]        commit_id_i;
  logic                   commit_kill_i;
  logic                   acc_rvalid_i;
  logic [DATA_W-1:0]      acc_result_i;
  logic [$clog2(DEPTH):0] count_o;
  logic                   full_o;
  logic                   empty_o;
  logic                   err_o;

  xava_result_queue_if #(.DATA_W(DATA_W), .ID_W(ID_W), .RD_W(RD_W)) rif ();

  xava_result_queue #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ID_W  (ID_W),
    .RD_W  (RD_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .iss_valid_i   (iss_valid_i),
    .iss_ready_o   (iss_ready_o),
    .iss_id_i      (iss_id_i),
    .iss_rd_i      (iss_rd_i),
    .iss_wb_i      (iss_wb_i),
    .commit_valid_i(commit_valid_i),
    .commit_id_i   (commit_id_i),
    .commit_kill_i (commit_kill_i),
    .acc_rvalid_i  (acc_rvalid_i),
    .acc_result_i  (acc_result_i),
    .res           (rif),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_cmp = 0;
  int   n_err = 0;
  pkt_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid_i    = 1'b0;
    commit_valid_i = 1'b0;
    acc_rvalid_i   = 1'b0;
  endtask

  task automatic issue(input logic [ID_W-1:0] id, input logic [RD_W-1:0] rd, input logic wb);
    iss_valid_i = 1'b1;
    iss_id_i    = id;
    iss_rd_i    = rd;
    iss_wb_i    = wb;
    cycle();
    idle_inputs();
  endtask

  task automatic commit(input logic [ID_W-1:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    cycle();
    idle_inputs();
  endtask

  task automatic result(input logic [DATA_W-1:0] d);
    acc_rvalid_i = 1'b1;
    acc_result_i = d;
    cycle();
    idle_inputs();
  endtask

  task automatic expect_pkt(input logic [ID_W-1:0] id, input logic [RD_W-1:0] rd,
                            input logic [DATA_W-1:0] d);
    pkt_t p;
    p.id   = id;
    p.rd   = rd;
    p.data = d;
    exp_q.push_back(p);
  endtask

  // Bounded drain: wait for the queue to empty, then check scoreboard is drained.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (!empty_o && n < 20) begin
      cycle();
      n++;
    end
    cycle();
    chk({name, "_empty"}, 32'(empty_o), 32'd1);
    chk({name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_iss_ready"}, 32'(iss_ready_o), 32'd1);
    chk({name, "_valid"}, 32'(rif.result_valid), 32'd0);
    chk({name, "_we"}, 32'(rif.result_we), 32'd0);
    chk({name, "_id"}, 32'(rif.result_id), 32'd0);
    chk({name, "_data"}, rif.result_data, 32'd0);
    chk({name, "_count"}, 32'(count_o), 32'd0);
    chk({name, "_empty"}, 32'(empty_o), 32'd1);
    chk({name, "_full"}, 32'(full_o), 32'd0);
    chk({name, "_err"}, 32'(err_o), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted packet and checks hold stability.
  logic              stall_seen = 1'b0;
  logic [ID_W-1:0]   held_id;
  logic [RD_W-1:0]   held_rd;
  logic [DATA_W-1:0] held_data;

  always @(negedge clk_i) begin
    pkt_t e;
    if (rst_i) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        n_cmp++;
        if (rif.result_valid !== 1'b1 || rif.result_id !== held_id ||
            rif.result_rd !== held_rd || rif.result_data !== held_data) begin
          n_err++;
          $display("FAIL hold_stable: got v=%0b id=%0h rd=%0h data=%0h, expected v=1 id=%0h rd=%0h data=%0h",
                   rif.result_valid, rif.result_id, rif.result_rd, rif.result_data,
                   held_id, held_rd, held_data);
        end
      end
      if (rif.result_valid === 1'b1 && rif.result_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: got id=%0h data=%0h, expected no packet",
                   rif.result_id, rif.result_data);
        end else begin
          e = exp_q.pop_front();
          if (rif.result_id !== e.id || rif.result_rd !== e.rd ||
              rif.result_data !== e.data || rif.result_we !== 1'b1) begin
            n_err++;
            $display("FAIL result_pkt: got id=%0h rd=%0h data=%0h we=%0b, expected id=%0h rd=%0h data=%0h we=1",
                     rif.result_id, rif.result_rd, rif.result_data, rif.result_we,
                     e.id, e.rd, e.data);
          end
        end
      end
      stall_seen = (rif.result_valid === 1'b1) && (rif.result_ready !== 1'b1);
      held_id    = rif.result_id;
      held_rd    = rif.result_rd;
      held_data  = rif.result_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i            = 1'b1;
    rif.result_ready = 1'b1;
    iss_id_i         = '0;
    iss_rd_i         = '0;
    iss_wb_i         = 1'b0;
    commit_id_i      = '0;
    commit_kill_i    = 1'b0;
    acc_result_i     = '0;
    idle_inputs();
    cycle();
    cycle();
    rst_i = 1'b0;
    check_reset_state("reset");

    // Single instruction.
    issue(4'd3, 5'd5, 1'b1);
    chk("single_count", 32'(count_o), 32'd1);
    chk("single_not_empty", 32'(empty_o), 32'd0);
    commit(4'd3, 1'b0);
    chk("single_no_valid_before_result", 32'(rif.result_valid), 32'd0);
    expect_pkt(4'd3, 5'd5, 32'hDEADBEEF);
    result(32'hDEADBEEF);
    chk("single_valid_latency", 32'(rif.result_valid), 32'd1);
    cycle();
    chk("single_empty", 32'(empty_o), 32'd1);
    chk("single_valid_dropped", 32'(rif.result_valid), 32'd0);

    // Fill with backpressure.
    rif.result_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(4'(8 + i), 5'(1 + i), 1'b1);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_iss_ready", 32'(iss_ready_o), 32'd0);
    chk("fill_count", 32'(count_o), 32'd4);
    issue(4'd12, 5'd9, 1'b1);
    chk("fill_no_overflow", 32'(count_o), 32'd4);
    chk("fill_no_err", 32'(err_o), 32'd0);
    for (int i = 0; i < 4; i++) commit(4'(8 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      expect_pkt(4'(8 + i), 5'(1 + i), 32'hA0A0_0000 + 32'(i));
      result(32'hA0A0_0000 + 32'(i));
    end
    chk("fill_a_valid", 32'(rif.result_valid), 32'd1);
    chk("fill_a_id", 32'(rif.result_id), 32'd8);
    cycle();
    cycle();
    cycle();
    rif.result_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("fill_b2b_count", 32'(count_o), 32'(3 - k));
    end
    chk("fill_empty", 32'(empty_o), 32'd1);

    // Kill older, commit younger.
    issue(4'd1, 5'd11, 1'b1);
    issue(4'd2, 5'd12, 1'b1);
    commit(4'd1, 1'b1);
    commit(4'd2, 1'b0);
    result(32'h1111_1111);
    expect_pkt(4'd2, 5'd12, 32'h2222_2222);
    result(32'h2222_2222);
    drain("kill");
    chk("kill_no_err", 32'(err_o), 32'd0);

    // Mixed writeback.
    issue(4'd4, 5'd6, 1'b0);
    issue(4'd5, 5'd7, 1'b1);
    commit(4'd4, 1'b0);
    commit(4'd5, 1'b0);
    chk("mixed_nowb_retired", 32'(count_o), 32'd1);
    expect_pkt(4'd5, 5'd7, 32'hCAFE_F00D);
    result(32'hCAFE_F00D);
    drain("mixed");

    // Protocol error and reset.
    chk("err_pre", 32'(err_o), 32'd0);
    result(32'h0BAD_0BAD);
    chk("err_set", 32'(err_o), 32'd1);
    cycle();
    cycle();
    chk("err_sticky", 32'(err_o), 32'd1);
    issue(4'd7, 5'd3, 1'b1);
    chk("err_pre_reset_count", 32'(count_o), 32'd1);
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    check_reset_state("mid_reset");

    // Wrap with same-cycle commit bypass.
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        iss_valid_i    = 1'b1;
        iss_id_i       = 4'(i + 1);
        iss_rd_i       = 5'(i + 10);
        iss_wb_i       = 1'b1;
        commit_valid_i = 1'b1;
        commit_id_i    = 4'(i + 1);
        commit_kill_i  = 1'b0;
      end
      if (i > 0) begin
        acc_rvalid_i = 1'b1;
        acc_result_i = 32'h5000_0000 + 32'(i - 1);
        expect_pkt(4'(i), 5'(i + 9), 32'h5000_0000 + 32'(i - 1));
      end
      cycle();
      idle_inputs();
      chk("wrap_count_bound", 32'(count_o <= 3'(DEPTH)), 32'd1);
    end
    drain("wrap");
    chk("wrap_no_err", 32'(err_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
